// File: rtl/reg_bus_host.sv
// reg_bus_host
// Register-bus front end for a bank of subregister slices. It accepts one
// outstanding read or write request at a time, decodes the word address and
// raises a single-cycle write strobe (reg_we_o) or read pulse (reg_re_o) to
// the addressed slice. It then returns a response carrying the read data and
// an error flag.
//
// Ports
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   req_valid_i/ready_o  request handshake; ready is high only in IDLE
//   req_write_i          1 = write, 0 = read
//   req_addr_i [AW]      byte address; register i lives at 4*i
//   req_wdata_i [DW]     write data
//   req_be_i [DW/8]      byte enables; a write must enable every byte
//   rsp_valid_o/ready_i  response handshake
//   rsp_rdata_o [DW]     read data (0 for writes and errors)
//   rsp_error_o          access error
//   reg_we_o [NumRegs]   one-hot write strobe
//   reg_re_o [NumRegs]   one-hot read pulse (drives read-clear registers)
//   reg_wd_o [DW]        write data shared by all slices
//   reg_qs_i [NumRegs*DW] packed slice values, register i at [i*DW +: DW]
module reg_bus_host #(
   parameter int NumRegs = 4,
   parameter int AW      = 8,
   parameter int DW      = 32
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  req_valid_i,
   output logic                  req_ready_o,
   input  logic                  req_write_i,
   input  logic [AW-1:0]         req_addr_i,
   input  logic [DW-1:0]         req_wdata_i,
   input  logic [DW/8-1:0]       req_be_i,
   output logic                  rsp_valid_o,
   input  logic                  rsp_ready_i,
   output logic [DW-1:0]         rsp_rdata_o,
   output logic                  rsp_error_o,
   output logic [NumRegs-1:0]    reg_we_o,
   output logic [NumRegs-1:0]    reg_re_o,
   output logic [DW-1:0]         reg_wd_o,
   input  logic [NumRegs*DW-1:0] reg_qs_i
);

   localparam int BW = DW / 8;
   localparam int IW = AW - 2;
   // Register count in a full AW-bit field, so the range check compares every
   // index bit and cannot alias an out-of-range address onto a real register.
   localparam logic [AW-1:0] NumRegsAw = AW'(NumRegs);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_e;

   state_e          state_q, state_d;
   logic            write_q, write_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic            err_q, err_d;
   logic [DW-1:0]   wd_q, wd_d;
   logic [DW-1:0]   rdata_q, rdata_d;
   logic            error_q, error_d;

   logic [AW-1:0]   req_idx_ext;
   logic            req_err;
   logic [DW-1:0]   qs_sel;

   // Request decode
   always_comb begin
      req_idx_ext = {2'b00, req_addr_i[AW-1:2]};
      req_err     = (req_addr_i[1:0] != 2'b00)
                  | (req_idx_ext >= NumRegsAw)
                  | (req_write_i & (req_be_i != {BW{1'b1}}));
   end

   // Slice value mux; only meaningful for in-range indices (err_q clear).
   always_comb begin
      qs_sel = '0;
      for (int i = 0; i < NumRegs; i++) begin
         if (idx_q == IW'(i)) qs_sel = reg_qs_i[i*DW +: DW];
      end
   end

   // Strobes decode straight from registered state, so an asynchronous reset
   // removes them at once without waiting for a clock edge.
   always_comb begin
      reg_we_o = '0;
      reg_re_o = '0;
      for (int i = 0; i < NumRegs; i++) begin
         if ((state_q == ST_ACCESS) && !err_q && (idx_q == IW'(i))) begin
            reg_we_o[i] = write_q;
            reg_re_o[i] = !write_q;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      write_d = write_q;
      idx_d   = idx_q;
      err_d   = err_q;
      wd_d    = wd_q;
      rdata_d = rdata_q;
      error_d = error_q;
      unique case (state_q)
         ST_IDLE: begin
            if (req_valid_i) begin
               write_d = req_write_i;
               idx_d   = req_addr_i[AW-1:2];
               err_d   = req_err;
               if (req_write_i) wd_d = req_wdata_i;
               state_d = ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            // Captured in the same cycle as the read pulse, so a read-clear
            // register reports its value from before the clear.
            rdata_d = (!write_q && !err_q) ? qs_sel : '0;
            error_d = err_q;
            state_d = ST_RESP;
         end
         ST_RESP: begin
            if (rsp_ready_i) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ST_IDLE;
         write_q <= 1'b0;
         idx_q   <= '0;
         err_q   <= 1'b0;
         wd_q    <= '0;
         rdata_q <= '0;
         error_q <= 1'b0;
      end else begin
         state_q <= state_d;
         write_q <= write_d;
         idx_q   <= idx_d;
         err_q   <= err_d;
         wd_q    <= wd_d;
         rdata_q <= rdata_d;
         error_q <= error_d;
      end
   end

   // Ready is gated by reset so it stays low while rst_ni is asserted.
   assign req_ready_o = rst_ni && (state_q == ST_IDLE);
   assign rsp_valid_o = (state_q == ST_RESP);
   assign rsp_rdata_o = rdata_q;
   assign rsp_error_o = error_q;
   assign reg_wd_o    = wd_q;

endmodule
